id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode pipeline stage of the 32-bit single-issue CPU; sits directly upstream of Registerfile.
- Accepts fetched instructions from IF, drives Registerfile read addresses A1/A2, and captures RD1/RD2.
- Applies EX/MEM/WB forwarding, detects load-use hazards and produces the registered ID/EX bundle consumed by the execute stage.

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register index width.
- PC_W, 32, program counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  ID accepts the IF instruction this cycle
- in_instr  in  32  MIPS instruction word
- in_pc  in  PC_W  PC of in_instr
- flush  in  1  branch/jump redirect; kill ID contents
- rf_a1  out  RADDR_W  Registerfile A1 (= in_instr[25:21])
- rf_a2  out  RADDR_W  Registerfile A2 (= in_instr[20:16])
- rf_rd1  in  XLEN  Registerfile RD1
- rf_rd2  in  XLEN  Registerfile RD2
- ex_we, ex_is_load  in  1 each  EX-stage instr writes reg / is lw
- ex_dst  in  RADDR_W;  ex_result  in  XLEN  EX destination and ALU result
- mem_we  in  1;  mem_dst  in  RADDR_W;  mem_result  in  XLEN  MEM-stage write info
- wb_we  in  1;  wb_dst  in  RADDR_W;  wb_result  in  XLEN  WB write info (same values driven to WE3/A3/WD3)
- out_valid  out  1  ID/EX bundle valid
- out_ready  in  1  EX accepts bundle
- out_pc  out  PC_W
- out_opcode  out  6;  out_funct  out  6;  out_shamt  out  5
- out_rs_val, out_rt_val  out  XLEN  forwarded operands
- out_imm  out  XLEN  extended immediate
- out_dst  out  RADDR_W  destination register (0 if none)
- out_we  out  1  instruction writes a register
- out_is_load, out_is_store  out  1 each

Behaviour:
- Reset: all out_* registers are 0. out_valid=0. Reset is asynchronous and acts mid-operation (drops any in-flight bundle).
- rf_a1/rf_a2: combinational from in_instr. RD values are used in the same cycle.
- Decode:
  - opcode 0x00 (R-type) -> dst=rd, we=1, uses rt.
  - 0x23 lw -> dst=rt, load.
  - 0x2B sw -> we=0, store, uses rt.
  - 0x08 addi / 0x0A slti -> sign-extend imm, dst=rt.
  - 0x0C andi / 0x0D ori -> zero-extend imm, dst=rt.
  - 0x0F lui -> imm<<16, dst=rt.
  - 0x04 beq / 0x05 bne -> we=0, uses rt, sign-extend imm.
  - Other opcodes -> we=0, dst=0 (NOP).
  - dst==0 forces we=0.
- Forwarding per operand, priority EX > MEM > WB > Registerfile.
  - A source matches a stage when that stage's we=1, its dst!=0 and dst equals the source index.
  - A source index of 0 always yields 0.
  - EX forwarding is never taken for a load; that case is a hazard.
- Load-use hazard: ex_is_load && ex_dst!=0 && (ex_dst==rs || (uses_rt && ex_dst==rt)).
  - in_ready=0; a bubble (out_valid=0) is loaded if EX accepts; instruction held by IF.
- Handshake:
  - in_ready = !hazard && (!out_valid || out_ready) && !flush.
  - The bundle register loads when (!out_valid || out_ready).
  - The loaded valid is in_valid && in_ready.
  - When out_valid && !out_ready, all out_* hold stable.
- flush: at the next edge out_valid=0 regardless of out_ready; the instruction offered that cycle is not accepted.
- Latency: 1 cycle from acceptance to out_valid. Throughput 1/cycle absent hazards.
- Simultaneous hazard and out_ready=0: hold (stall dominates); no bubble inserted until EX accepts.

Decomposition:
- Shared package cpu_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_BEQ, OP_BNE), XLEN, RADDR_W, and an id_ex_t bundle typedef.
- One sub-module: id_fwd_mux (one instance per operand; index, RF value and three stage tuples in, forwarded value out).

Test Plan:
- Reset mid-stream: assert rst with out_valid=1 -> out_valid=0 and all out_* =0 immediately; in_ready=1 after release.
- addi $1,$0,-5 (0x2001FFFB) -> one cycle later out_imm=0xFFFFFFFB, out_dst=1, out_we=1. ori with imm 0x8000 -> out_imm=0x00008000.
- Forward priority: add $3,$1,$4 with rf_rd1=1, wb writes $1=7, mem writes $1=9, ex writes $1=11 -> out_rs_val=11. Drop ex -> 9. Drop mem -> 7.
- Load-use: ex_is_load=1, ex_dst=4, instr add $5,$4,$1 -> in_ready=0, next out_valid=0; clear ex_is_load -> accepted, out_rt_val=rf_rd2.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_* stable, in_ready=0; out_ready=1 -> next instruction loads.
- flush with in_valid=1 -> in_ready=0, next out_valid=0; $0 source with wb_dst=0, wb_we=1, wb_result=0xFFFF -> operand 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, datapath widths and the
// ID/EX bundle plus forwarding-source tuple types.
package cpu_pkg;

   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;
   localparam int PC_W    = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // One downstream stage's register-write intent, as seen by a forwarding mux.
   typedef struct packed {
      logic               we;
      logic [RADDR_W-1:0] dst;
      logic [XLEN-1:0]    data;
   } fwd_src_t;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [5:0]         opcode;
      logic [5:0]         funct;
      logic [4:0]         shamt;
      logic [XLEN-1:0]    rs_val;
      logic [XLEN-1:0]    rt_val;
      logic [XLEN-1:0]    imm;
      logic [RADDR_W-1:0] dst;
      logic               we;
      logic               is_load;
      logic               is_store;
   } id_ex_t;

   function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
      return {{(XLEN-16){v[15]}}, v};
   endfunction

   function automatic logic [XLEN-1:0] zext16(input logic [15:0] v);
      return {{(XLEN-16){1'b0}}, v};
   endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand forwarding for one source register: EX over MEM over WB over
// the register file, with register 0 hard-wired to zero.
module id_fwd_mux
   import cpu_pkg::*;
(
   input  logic [RADDR_W-1:0] idx,
   input  logic [XLEN-1:0]    rf_val,
   input  fwd_src_t           ex_src,
   input  fwd_src_t           mem_src,
   input  fwd_src_t           wb_src,
   output logic [XLEN-1:0]    val
);

   function automatic logic hit(input fwd_src_t s, input logic [RADDR_W-1:0] i);
      return s.we && (s.dst != '0) && (s.dst == i);
   endfunction

   always_comb begin
      val = rf_val;
      if (idx == '0)
         val = '0;
      else if (hit(ex_src, idx))
         val = ex_src.data;
      else if (hit(mem_src, idx))
         val = mem_src.data;
      else if (hit(wb_src, idx))
         val = wb_src.data;
   end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: register-file read, operand forwarding,
// load-use stall and the registered ID/EX bundle.
module id_stage #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int PC_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               flush,
   output logic [RADDR_W-1:0] rf_a1,
   output logic [RADDR_W-1:0] rf_a2,
   input  logic [XLEN-1:0]    rf_rd1,
   input  logic [XLEN-1:0]    rf_rd2,
   input  logic               ex_we,
   input  logic               ex_is_load,
   input  logic [RADDR_W-1:0] ex_dst,
   input  logic [XLEN-1:0]    ex_result,
   input  logic               mem_we,
   input  logic [RADDR_W-1:0] mem_dst,
   input  logic [XLEN-1:0]    mem_result,
   input  logic               wb_we,
   input  logic [RADDR_W-1:0] wb_dst,
   input  logic [XLEN-1:0]    wb_result,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [5:0]         out_opcode,
   output logic [5:0]         out_funct,
   output logic [4:0]         out_shamt,
   output logic [XLEN-1:0]    out_rs_val,
   output logic [XLEN-1:0]    out_rt_val,
   output logic [XLEN-1:0]    out_imm,
   output logic [RADDR_W-1:0] out_dst,
   output logic               out_we,
   output logic               out_is_load,
   output logic               out_is_store
);

   import cpu_pkg::*;

   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic [4:0]         shamt;
   logic [RADDR_W-1:0] rs;
   logic [RADDR_W-1:0] rt;
   logic [RADDR_W-1:0] rd;
   logic [15:0]        imm16;

   assign opcode = in_instr[31:26];
   assign rs     = in_instr[25:21];
   assign rt     = in_instr[20:16];
   assign rd     = in_instr[15:11];
   assign shamt  = in_instr[10:6];
   assign funct  = in_instr[5:0];
   assign imm16  = in_instr[15:0];

   assign rf_a1 = rs;
   assign rf_a2 = rt;

   logic               uses_rt;
   logic [XLEN-1:0]    imm_ext;
   logic [RADDR_W-1:0] dst_dec;
   logic               we_dec;

   always_comb begin
      uses_rt = 1'b0;
      imm_ext = '0;
      dst_dec = '0;
      case (opcode)
         OP_RTYPE: begin
            dst_dec = rd;
            uses_rt = 1'b1;
         end
         OP_LW: begin
            dst_dec = rt;
            imm_ext = sext16(imm16);
         end
         OP_SW: begin
            uses_rt = 1'b1;
            imm_ext = sext16(imm16);
         end
         OP_ADDI, OP_SLTI: begin
            dst_dec = rt;
            imm_ext = sext16(imm16);
         end
         OP_ANDI, OP_ORI: begin
            dst_dec = rt;
            imm_ext = zext16(imm16);
         end
         OP_LUI: begin
            dst_dec = rt;
            imm_ext = {imm16, {(XLEN-16){1'b0}}};
         end
         OP_BEQ, OP_BNE: begin
            uses_rt = 1'b1;
            imm_ext = sext16(imm16);
         end
         default: begin
            dst_dec = '0;
         end
      endcase
   end

   // Writes to $0 are discarded, so an instruction targeting it never writes.
   assign we_dec = (dst_dec != '0);

   // A load in EX has no data yet; it must not forward, the stall covers it.
   fwd_src_t ex_src, mem_src, wb_src;
   assign ex_src  = '{we: ex_we && !ex_is_load, dst: ex_dst, data: ex_result};
   assign mem_src = '{we: mem_we, dst: mem_dst, data: mem_result};
   assign wb_src  = '{we: wb_we, dst: wb_dst, data: wb_result};

   logic [XLEN-1:0] rs_fwd;
   logic [XLEN-1:0] rt_fwd;

   id_fwd_mux u_fwd_rs (
      .idx     (rs),
      .rf_val  (rf_rd1),
      .ex_src  (ex_src),
      .mem_src (mem_src),
      .wb_src  (wb_src),
      .val     (rs_fwd)
   );

   id_fwd_mux u_fwd_rt (
      .idx     (rt),
      .rf_val  (rf_rd2),
      .ex_src  (ex_src),
      .mem_src (mem_src),
      .wb_src  (wb_src),
      .val     (rt_fwd)
   );

   logic hazard;
   assign hazard = ex_is_load && (ex_dst != '0) &&
                   ((ex_dst == rs) || (uses_rt && (ex_dst == rt)));

   // Handshake: a transfer happens on an edge where valid and ready are both
   // high; the producer holds its payload stable while valid && !ready.
   logic load_en;
   logic accept;
   assign load_en  = !out_valid || out_ready;
   assign in_ready = !hazard && load_en && !flush;
   assign accept   = in_valid && in_ready;

   id_ex_t nxt;
   id_ex_t bundle;

   always_comb begin
      nxt          = '0;
      nxt.pc       = in_pc;
      nxt.opcode   = opcode;
      nxt.funct    = funct;
      nxt.shamt    = shamt;
      nxt.rs_val   = rs_fwd;
      nxt.rt_val   = rt_fwd;
      nxt.imm      = imm_ext;
      nxt.dst      = dst_dec;
      nxt.we       = we_dec;
      nxt.is_load  = (opcode == OP_LW);
      nxt.is_store = (opcode == OP_SW);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         bundle    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load_en) begin
         out_valid <= accept;
         if (accept)
            bundle <= nxt;
      end
   end

   assign out_pc       = bundle.pc;
   assign out_opcode   = bundle.opcode;
   assign out_funct    = bundle.funct;
   assign out_shamt    = bundle.shamt;
   assign out_rs_val   = bundle.rs_val;
   assign out_rt_val   = bundle.rt_val;
   assign out_imm      = bundle.imm;
   assign out_dst      = bundle.dst;
   assign out_we       = bundle.we;
   assign out_is_load  = bundle.is_load;
   assign out_is_store = bundle.is_store;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a decode/forwarding vector table plus
// hand sequences for reset, load-use stall, backpressure and flush.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic [4:0]  rf_a1, rf_a2;
   logic [31:0] rf_rd1, rf_rd2;
   logic        ex_we, ex_is_load;
   logic [4:0]  ex_dst;
   logic [31:0] ex_result;
   logic        mem_we;
   logic [4:0]  mem_dst;
   logic [31:0] mem_result;
   logic        wb_we;
   logic [4:0]  wb_dst;
   logic [31:0] wb_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [5:0]  out_opcode, out_funct;
   logic [4:0]  out_shamt;
   logic [31:0] out_rs_val, out_rt_val, out_imm;
   logic [4:0]  out_dst;
   logic        out_we, out_is_load, out_is_store;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   id_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_dst(ex_dst), .ex_result(ex_result),
      .mem_we(mem_we), .mem_dst(mem_dst), .mem_result(mem_result),
      .wb_we(wb_we), .wb_dst(wb_dst), .wb_result(wb_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_funct(out_funct), .out_shamt(out_shamt),
      .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm),
      .out_dst(out_dst), .out_we(out_we), .out_is_load(out_is_load),
      .out_is_store(out_is_store)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rd1, rd2;
      logic        ex_we, ex_ld;
      logic [4:0]  ex_dst;
      logic [31:0] ex_res;
      logic        mem_we;
      logic [4:0]  mem_dst;
      logic [31:0] mem_res;
      logic        wb_we;
      logic [4:0]  wb_dst;
      logic [31:0] wb_res;
      logic [31:0] e_rs, e_rt, e_imm;
      logic        chk_imm;
      logic [4:0]  e_dst;
      logic        e_we, e_ld, e_st;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t base(input logic [31:0] instr, input logic [31:0] rd1,
                                 input logic [31:0] rd2);
      vec_t v;
      v.instr = instr;   v.pc = 32'h0;      v.rd1 = rd1;     v.rd2 = rd2;
      v.ex_we = 1'b0;    v.ex_ld = 1'b0;    v.ex_dst = '0;   v.ex_res = '0;
      v.mem_we = 1'b0;   v.mem_dst = '0;    v.mem_res = '0;
      v.wb_we = 1'b0;    v.wb_dst = '0;     v.wb_res = '0;
      v.e_rs = '0;       v.e_rt = '0;       v.e_imm = '0;    v.chk_imm = 1'b0;
      v.e_dst = '0;      v.e_we = 1'b0;     v.e_ld = 1'b0;   v.e_st = 1'b0;
      return v;
   endfunction

   function automatic vec_t with_exp(input vec_t vi, input logic [31:0] rs, input logic [31:0] rt,
                                     input logic [31:0] imm, input logic chk,
                                     input logic [4:0] dst, input logic we,
                                     input logic ld, input logic st);
      vec_t v = vi;
      v.e_rs = rs; v.e_rt = rt; v.e_imm = imm; v.chk_imm = chk;
      v.e_dst = dst; v.e_we = we; v.e_ld = ld; v.e_st = st;
      return v;
   endfunction

   task automatic clear_stages();
      ex_we = 0; ex_is_load = 0; ex_dst = 0; ex_result = 0;
      mem_we = 0; mem_dst = 0; mem_result = 0;
      wb_we = 0; wb_dst = 0; wb_result = 0;
   endtask

   task automatic drive(input vec_t v);
      in_instr = v.instr; in_pc = v.pc; rf_rd1 = v.rd1; rf_rd2 = v.rd2;
      ex_we = v.ex_we; ex_is_load = v.ex_ld; ex_dst = v.ex_dst; ex_result = v.ex_res;
      mem_we = v.mem_we; mem_dst = v.mem_dst; mem_result = v.mem_res;
      wb_we = v.wb_we; wb_dst = v.wb_dst; wb_result = v.wb_res;
   endtask

   task automatic build_table();
      vec_t v;
      // addi $1,$0,-5
      v = base(32'h2001FFFB, 32'hDEAD, 32'h22);
      vecs.push_back(with_exp(v, 32'h0, 32'h22, 32'hFFFFFFFB, 1, 5'd1, 1, 0, 0));
      // ori $2,$3,0x8000
      v = base(32'h34628000, 32'h33, 32'h44);
      vecs.push_back(with_exp(v, 32'h33, 32'h44, 32'h00008000, 1, 5'd2, 1, 0, 0));
      // add $3,$1,$4 with EX/MEM/WB all writing $1, then peeled off one by one
      v = base(32'h00241820, 32'h1, 32'h44);
      v.ex_we = 1; v.ex_dst = 1; v.ex_res = 32'd11;
      v.mem_we = 1; v.mem_dst = 1; v.mem_res = 32'd9;
      v.wb_we = 1; v.wb_dst = 1; v.wb_res = 32'd7;
      vecs.push_back(with_exp(v, 32'd11, 32'h44, 0, 0, 5'd3, 1, 0, 0));
      v.ex_we = 0;
      vecs.push_back(with_exp(v, 32'd9, 32'h44, 0, 0, 5'd3, 1, 0, 0));
      v.mem_we = 0;
      vecs.push_back(with_exp(v, 32'd7, 32'h44, 0, 0, 5'd3, 1, 0, 0));
      v.wb_we = 0;
      vecs.push_back(with_exp(v, 32'd1, 32'h44, 0, 0, 5'd3, 1, 0, 0));
      // sub $11,$2,$3 with EX forwarding to rt
      v = base(32'h00435822, 32'h22, 32'h33);
      v.ex_we = 1; v.ex_dst = 3; v.ex_res = 32'hABC;
      vecs.push_back(with_exp(v, 32'h22, 32'hABC, 0, 0, 5'd11, 1, 0, 0));
      // lw $6,-4($2) with MEM forwarding to rs
      v = base(32'h8C46FFFC, 32'h5, 32'h6);
      v.mem_we = 1; v.mem_dst = 2; v.mem_res = 32'h1000;
      vecs.push_back(with_exp(v, 32'h1000, 32'h6, 32'hFFFFFFFC, 1, 5'd6, 1, 1, 0));
      // sw $7,8($2) with WB forwarding to rt
      v = base(32'hAC470008, 32'h5, 32'h6);
      v.wb_we = 1; v.wb_dst = 7; v.wb_res = 32'h77;
      vecs.push_back(with_exp(v, 32'h5, 32'h77, 32'h8, 1, 5'd0, 0, 0, 1));
      // beq $1,$2,-1
      v = base(32'h1022FFFF, 32'h1, 32'h2);
      vecs.push_back(with_exp(v, 32'h1, 32'h2, 32'hFFFFFFFF, 1, 5'd0, 0, 0, 0));
      // andi $9,$1,0xFFFF
      v = base(32'h3029FFFF, 32'h1, 32'h2);
      vecs.push_back(with_exp(v, 32'h1, 32'h2, 32'h0000FFFF, 1, 5'd9, 1, 0, 0));
      // addi $0,$1,5: dst 0 forces we=0, rt index 0 reads as zero
      v = base(32'h20200005, 32'h1, 32'h99);
      vecs.push_back(with_exp(v, 32'h1, 32'h0, 32'h5, 1, 5'd0, 0, 0, 0));
      // unknown opcode 0x3F behaves as a NOP
      v = base(32'hFC221234, 32'h1, 32'h2);
      vecs.push_back(with_exp(v, 32'h1, 32'h2, 0, 0, 5'd0, 0, 0, 0));
      // add $10,$0,$0 with stages writing $0: operands stay zero
      v = base(32'h00005020, 32'h55, 32'h66);
      v.wb_we = 1; v.wb_dst = 0; v.wb_res = 32'hFFFF;
      v.ex_we = 1; v.ex_dst = 0; v.ex_res = 32'h123;
      vecs.push_back(with_exp(v, 32'h0, 32'h0, 0, 0, 5'd10, 1, 0, 0));
      // ori $2,$3 with a load in EX to $2 (unused rt): no stall, MEM value wins
      v = base(32'h34628000, 32'h33, 32'h44);
      v.ex_we = 1; v.ex_ld = 1; v.ex_dst = 2; v.ex_res = 32'hBAD;
      v.mem_we = 1; v.mem_dst = 2; v.mem_res = 32'h202;
      vecs.push_back(with_exp(v, 32'h33, 32'h202, 32'h00008000, 1, 5'd2, 1, 0, 0));
      // slti $12,$1,0x8000
      v = base(32'h282C8000, 32'h1, 32'h2);
      vecs.push_back(with_exp(v, 32'h1, 32'h2, 32'hFFFF8000, 1, 5'd12, 1, 0, 0));
      // lui $8,0x1234
      v = base(32'h3C081234, 32'h0, 32'h88);
      vecs.push_back(with_exp(v, 32'h0, 32'h88, 32'h12340000, 1, 5'd8, 1, 0, 0));
      foreach (vecs[i]) vecs[i].pc = 32'h400 + 32'(i) * 4;
   endtask

   task automatic send_simple(input logic [31:0] instr, input logic [31:0] pc);
      @(negedge clk);
      clear_stages();
      in_instr = instr; in_pc = pc; in_valid = 1; out_ready = 1; flush = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t v;
      rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 1;
      rf_rd1 = 0; rf_rd2 = 0;
      clear_stages();
      build_table();
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_dst", out_dst, 0);
      check("reset_out_imm", out_imm, 0);
      @(negedge clk);
      rst = 0;
      #1;
      check("reset_in_ready", in_ready, 1);

      // Table: one instruction per cycle, EX always ready
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge clk);
         drive(v);
         in_valid = 1; out_ready = 1; flush = 0;
         #1;
         check($sformatf("v%0d_in_ready", i), in_ready, 1);
         check($sformatf("v%0d_rf_a1", i), rf_a1, v.instr[25:21]);
         check($sformatf("v%0d_rf_a2", i), rf_a2, v.instr[20:16]);
         exp_q.push_back(v.e_rs);
         @(posedge clk); #1;
         check($sformatf("v%0d_out_valid", i), out_valid, 1);
         check($sformatf("v%0d_pc", i), out_pc, v.pc);
         check($sformatf("v%0d_opcode", i), out_opcode, v.instr[31:26]);
         check($sformatf("v%0d_funct", i), out_funct, v.instr[5:0]);
         check($sformatf("v%0d_rs_val", i), out_rs_val, exp_q.pop_front());
         check($sformatf("v%0d_rt_val", i), out_rt_val, v.e_rt);
         if (v.chk_imm) check($sformatf("v%0d_imm", i), out_imm, v.e_imm);
         check($sformatf("v%0d_dst", i), out_dst, v.e_dst);
         check($sformatf("v%0d_we", i), out_we, v.e_we);
         check($sformatf("v%0d_is_load", i), out_is_load, v.e_ld);
         check($sformatf("v%0d_is_store", i), out_is_store, v.e_st);
      end

      // Asynchronous reset with a valid bundle in flight
      @(negedge clk);
      in_valid = 0;
      #1;
      check("pre_rst_valid", out_valid, 1);
      rst = 1;
      #1;
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_imm", out_imm, 0);
      check("rst_mid_pc", out_pc, 0);
      check("rst_mid_dst", out_dst, 0);
      check("rst_mid_rt_val", out_rt_val, 0);
      @(negedge clk);
      rst = 0;
      #1;
      check("rst_rel_in_ready", in_ready, 1);

      // Load-use: lw in EX writes $4, add $5,$4,$1 must wait one bubble
      @(negedge clk);
      clear_stages();
      ex_we = 1; ex_is_load = 1; ex_dst = 4; ex_result = 32'hBAD;
      in_instr = 32'h00812820; in_pc = 32'h500; rf_rd1 = 32'h4444; rf_rd2 = 32'h1234;
      in_valid = 1; out_ready = 1;
      #1;
      check("lu_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("lu_bubble", out_valid, 0);
      @(negedge clk);
      ex_is_load = 0; ex_we = 0;
      #1;
      check("lu_release_ready", in_ready, 1);
      @(posedge clk); #1;
      check("lu_out_valid", out_valid, 1);
      check("lu_rt_val", out_rt_val, 32'h1234);
      check("lu_rs_val", out_rs_val, 32'h4444);
      check("lu_dst", out_dst, 5);

      // Backpressure: lui held for 3 cycles, then addi follows
      send_simple(32'h3C081234, 32'h600);
      check("bp_first_valid", out_valid, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         out_ready = 0; in_instr = 32'h2001FFFB; in_pc = 32'h604;
         #1;
         check($sformatf("bp%0d_in_ready", c), in_ready, 0);
         @(posedge clk); #1;
         check($sformatf("bp%0d_valid", c), out_valid, 1);
         check($sformatf("bp%0d_imm", c), out_imm, 32'h12340000);
         check($sformatf("bp%0d_dst", c), out_dst, 8);
         check($sformatf("bp%0d_pc", c), out_pc, 32'h600);
      end
      @(negedge clk);
      out_ready = 1;
      #1;
      check("bp_rel_in_ready", in_ready, 1);
      @(posedge clk); #1;
      check("bp_next_imm", out_imm, 32'hFFFFFFFB);
      check("bp_next_dst", out_dst, 1);
      check("bp_next_pc", out_pc, 32'h604);

      // Hazard while EX is stalled: hold first, bubble once EX accepts
      send_simple(32'h3C081234, 32'h700);
      @(negedge clk);
      out_ready = 0; ex_we = 1; ex_is_load = 1; ex_dst = 4;
      in_instr = 32'h00812820; in_pc = 32'h704;
      #1;
      check("hz_bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("hz_bp_hold_valid", out_valid, 1);
      check("hz_bp_hold_pc", out_pc, 32'h700);
      @(negedge clk);
      out_ready = 1;
      #1;
      check("hz_rel_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("hz_bubble", out_valid, 0);

      // Flush with an instruction offered: not accepted, no valid next cycle
      @(negedge clk);
      clear_stages();
      in_instr = 32'h2001FFFB; in_pc = 32'h800; in_valid = 1; out_ready = 1; flush = 1;
      #1;
      check("fl_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("fl_valid", out_valid, 0);
      @(negedge clk);
      flush = 0;

      // Flush overrides a stalled valid bundle
      send_simple(32'h3C081234, 32'h900);
      check("fl_bp_pre_valid", out_valid, 1);
      @(negedge clk);
      out_ready = 0; flush = 1; in_valid = 1;
      @(posedge clk); #1;
      check("fl_bp_valid", out_valid, 0);
      @(negedge clk);
      flush = 0; in_valid = 0; out_ready = 1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
